// File: rtl/sum_collector_if.sv
// Half-beat input and valid/ready result stream for sum_collector.
// master: adder-side producer and result consumer; slave: the collector.
interface sum_collector_if #(
   parameter int unsigned HALF_W = 16
);
   localparam int unsigned SUM_W = 2 * HALF_W + 1;

   logic              in_valid;
   logic [HALF_W-1:0] S_in;
   logic              C_in;
   logic              flag_in;
   logic              out_valid;
   logic              out_ready;
   logic [SUM_W-1:0]  sum_out;

   modport master (
      output in_valid, S_in, C_in, flag_in, out_ready,
      input  out_valid, sum_out
   );

   modport slave (
      input  in_valid, S_in, C_in, flag_in, out_ready,
      output out_valid, sum_out
   );
endinterface

// File: rtl/sum_collector.sv
// Pairs low/high adder sum halves into {carry, high, low} and queues them on a valid/ready port.
// Optional SUM_COLLECT_STATS_EN builds the res_cnt/drop_cnt counters; otherwise they read zero.
module sum_collector #(
   parameter int unsigned HALF_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   sum_collector_if.slave bus,
   input  logic        err_clr,
   output logic        seq_err,
   output logic        ovf_err,
   output logic [15:0] res_cnt,
   output logic [15:0] drop_cnt
);

   localparam int unsigned SUM_W = 2 * HALF_W + 1;
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned CNT_W = 16;

   typedef enum logic {
      LOW_WAIT  = 1'b0,
      HIGH_WAIT = 1'b1
   } state_t;

   state_t             state_q;
   state_t             state_nxt_c;
   logic [HALF_W-1:0]  low_q;
   logic               load_low_c;
   logic               seq_evt_c;
   logic               push_req_c;

   logic [SUM_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_nxt_c;
   logic [PTR_W-1:0]   rd_nxt_c;
   logic               full_c;
   logic               pop_c;
   logic               push_ok_c;
   logic               drop_c;
   logic [SUM_W-1:0]   push_data_c;
   logic [SUM_W-1:0]   head_nxt_c;
   logic               out_valid_q;
   logic [SUM_W-1:0]   sum_q;

   // FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= LOW_WAIT;
      else        state_q <= state_nxt_c;
   end

   // FSM next state
   always_comb begin
      state_nxt_c = state_q;
      if (bus.in_valid) begin
         unique case (state_q)
            LOW_WAIT:  if (!bus.flag_in) state_nxt_c = HIGH_WAIT;
            HIGH_WAIT: if (bus.flag_in)  state_nxt_c = LOW_WAIT;
            default:   state_nxt_c = LOW_WAIT;
         endcase
      end
   end

   // FSM outputs: a low beat always (re)loads the held half
   always_comb begin
      load_low_c = 1'b0;
      seq_evt_c  = 1'b0;
      push_req_c = 1'b0;
      if (bus.in_valid) begin
         load_low_c = !bus.flag_in;
         unique case (state_q)
            LOW_WAIT:  seq_evt_c = bus.flag_in;
            HIGH_WAIT: begin
               seq_evt_c  = !bus.flag_in;
               push_req_c = bus.flag_in;
            end
            default:   seq_evt_c = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)          low_q <= '0;
      else if (load_low_c) low_q <= bus.S_in;
   end

   // FIFO control; a full FIFO still accepts a push when the head pops in the same cycle
   always_comb begin
      full_c      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
      pop_c       = out_valid_q & bus.out_ready;
      push_ok_c   = push_req_c & (!full_c | pop_c);
      drop_c      = push_req_c & full_c & !pop_c;
      push_data_c = {bus.C_in, bus.S_in, low_q};
      rd_nxt_c    = rd_ptr + PTR_W'(pop_c);
      wr_nxt_c    = wr_ptr + PTR_W'(push_ok_c);
      head_nxt_c  = (push_ok_c && (wr_ptr == rd_nxt_c)) ? push_data_c
                                                        : mem[rd_nxt_c[IDX_W-1:0]];
   end

   always_ff @(posedge CLK) begin
      if (push_ok_c) mem[wr_ptr[IDX_W-1:0]] <= push_data_c;
   end

   // Head is registered so out_valid/sum_out come straight from flops
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
      end else begin
         wr_ptr      <= wr_nxt_c;
         rd_ptr      <= rd_nxt_c;
         out_valid_q <= (wr_nxt_c != rd_nxt_c);
         if (wr_nxt_c != rd_nxt_c) sum_q <= head_nxt_c;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sum_out   = sum_q;

   // Sticky error flags; a new event beats a simultaneous clear
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         seq_err <= 1'b0;
         ovf_err <= 1'b0;
      end else begin
         seq_err <= seq_evt_c | (seq_err & !err_clr);
         ovf_err <= drop_c    | (ovf_err & !err_clr);
      end
   end

`ifdef SUM_COLLECT_STATS_EN
   logic [CNT_W-1:0] res_cnt_q;
   logic [CNT_W-1:0] drop_cnt_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         res_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (push_ok_c) res_cnt_q  <= res_cnt_q + CNT_W'(1);
         if (drop_c)    drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
   end

   assign res_cnt  = res_cnt_q;
   assign drop_cnt = drop_cnt_q;
`else
   assign res_cnt  = CNT_W'(0);
   assign drop_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_sum_collector.sv
// Self-checking bench for sum_collector: directed plan scenarios plus random beats vs a queue model.
module tb_sum_collector;

   localparam int unsigned HALF_W = 16;
   localparam int unsigned DEPTH  = 4;

   logic        clk;
   logic        rst_n;
   logic        err_clr;
   logic        seq_err;
   logic        ovf_err;
   logic [15:0] res_cnt;
   logic [15:0] drop_cnt;

   int errors = 0;
   int checks = 0;

   sum_collector_if #(.HALF_W(HALF_W)) bus ();

   sum_collector #(.HALF_W(HALF_W), .DEPTH(DEPTH)) dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .bus      (bus.slave),
      .err_clr  (err_clr),
      .seq_err  (seq_err),
      .ovf_err  (ovf_err),
      .res_cnt  (res_cnt),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [32:0] m_q[$];
   logic [32:0] m_last;
   bit          m_pend;
   logic [15:0] m_low;
   bit          m_seq;
   bit          m_ovf;
   logic [15:0] m_rc;
   logic [15:0] m_dc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] cnt_exp(input logic [15:0] x);
`ifdef SUM_COLLECT_STATS_EN
      return x;
`else
      return 16'h0000;
`endif
   endfunction

   function automatic logic [32:0] res_of(input int i);
      logic [15:0] hi;
      logic [15:0] lo;
      hi = 16'(i);
      lo = 16'(i * 17);
      return {1'(i & 1), hi, lo};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_last = '0;
      m_pend = 0;
      m_low  = '0;
      m_seq  = 0;
      m_ovf  = 0;
      m_rc   = '0;
      m_dc   = '0;
   endtask

   task automatic model_update(input logic v, input logic [15:0] s, input logic c,
                               input logic f, input logic rdy, input logic clr);
      bit seq_evt;
      bit drop_evt;
      seq_evt  = 0;
      drop_evt = 0;
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (v) begin
         if (!m_pend) begin
            if (!f) begin m_pend = 1; m_low = s; end
            else seq_evt = 1;
         end else begin
            if (f) begin
               m_pend = 0;
               if (m_q.size() < DEPTH) begin
                  m_q.push_back({c, s, m_low});
                  m_rc++;
               end else begin
                  drop_evt = 1;
                  m_dc++;
               end
            end else begin
               m_low   = s;
               seq_evt = 1;
            end
         end
      end
      m_seq = seq_evt  ? 1 : (clr ? 0 : m_seq);
      m_ovf = drop_evt ? 1 : (clr ? 0 : m_ovf);
      if (m_q.size() > 0) m_last = m_q[0];
   endtask

   task automatic compare_all();
      check("out_valid", bus.out_valid, m_q.size() != 0);
      check("sum_out",   bus.sum_out,   m_last);
      check("seq_err",   seq_err,       m_seq);
      check("ovf_err",   ovf_err,       m_ovf);
      check("res_cnt",   res_cnt,       cnt_exp(m_rc));
      check("drop_cnt",  drop_cnt,      cnt_exp(m_dc));
   endtask

   task automatic step(input logic v, input logic [15:0] s, input logic c,
                       input logic f, input logic rdy, input logic clr);
      bus.in_valid  = v;
      bus.S_in      = s;
      bus.C_in      = c;
      bus.flag_in   = f;
      bus.out_ready = rdy;
      err_clr       = clr;
      @(posedge clk);
      model_update(v, s, c, f, rdy, clr);
      #1;
      compare_all();
   endtask

   task automatic idle(input logic rdy, input logic clr);
      step(1'b0, 16'h0000, 1'b0, 1'b0, rdy, clr);
   endtask

   task automatic pair_i(input int i, input logic rdy_hi);
      step(1'b1, 16'(i * 17), 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'(i), 1'(i & 1), 1'b1, rdy_hi, 1'b0);
   endtask

   initial begin
      rst_n         = 1'b0;
      err_clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.S_in      = '0;
      bus.C_in      = 1'b0;
      bus.flag_in   = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();
      #3;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_sum_out",   bus.sum_out,   33'h0);
      check("rst_seq_err",   seq_err,       1'b0);
      check("rst_ovf_err",   ovf_err,       1'b0);
      check("rst_res_cnt",   res_cnt,       16'h0);
      check("rst_drop_cnt",  drop_cnt,      16'h0);
      #8 rst_n = 1'b1;
      idle(1'b0, 1'b0);

      // Basic pair
      step(1'b1, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0);
      check("basic_valid", bus.out_valid, 1'b1);
      check("basic_sum",   bus.sum_out,   33'h1_1234_5678);
      check("basic_cnt",   res_cnt,       cnt_exp(16'd1));
      idle(1'b1, 1'b0);
      check("basic_popped", bus.out_valid, 1'b0);

      // Sequence error and restart of a pair
      step(1'b1, 16'h7777, 1'b1, 1'b1, 1'b1, 1'b0);
      check("seq_first_high", seq_err, 1'b1);
      step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0);
      check("seq_sum",    bus.sum_out, 33'h0_0001_BBBB);
      idle(1'b1, 1'b0);
      check("seq_sticky", seq_err, 1'b1);
      idle(1'b1, 1'b1);
      check("seq_clr",    seq_err, 1'b0);
      step(1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b1);
      check("seq_beats_clr", seq_err, 1'b1);
      idle(1'b1, 1'b1);

      // Overflow: 5 pairs into a 4-deep FIFO with no consumer
      for (int i = 1; i <= 5; i++) pair_i(i, 1'b0);
      check("ovf_flag", ovf_err,  1'b1);
      check("ovf_drop", drop_cnt, cnt_exp(16'd1));
      for (int k = 1; k <= 4; k++) begin
         check("ovf_drain_valid", bus.out_valid, 1'b1);
         check("ovf_drain_data",  bus.sum_out,   res_of(k));
         idle(1'b1, 1'b0);
      end
      check("ovf_empty", bus.out_valid, 1'b0);
      idle(1'b1, 1'b1);

      // Full FIFO with a pop on the high-half beat
      for (int i = 11; i <= 14; i++) pair_i(i, 1'b0);
      pair_i(15, 1'b1);
      check("fullpop_ovf", ovf_err, 1'b0);
      for (int k = 12; k <= 15; k++) begin
         check("fullpop_valid", bus.out_valid, 1'b1);
         check("fullpop_data",  bus.sum_out,   res_of(k));
         idle(1'b1, 1'b0);
      end
      check("fullpop_empty", bus.out_valid, 1'b0);

      // Reset in the middle of a pair
      step(1'b1, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      model_reset();
      #2;
      check("mrst_valid", bus.out_valid, 1'b0);
      check("mrst_sum",   bus.sum_out,   33'h0);
      check("mrst_seq",   seq_err,       1'b0);
      check("mrst_ovf",   ovf_err,       1'b0);
      check("mrst_res",   res_cnt,       16'h0);
      check("mrst_drop",  drop_cnt,      16'h0);
      rst_n = 1'b1;
      step(1'b1, 16'h9999, 1'b1, 1'b1, 1'b1, 1'b0);
      check("mrst_high_seq",   seq_err,       1'b1);
      check("mrst_high_valid", bus.out_valid, 1'b0);

      // Random beats against the model
      for (int n = 0; n < 800; n++) begin
         step(1'($urandom_range(0, 3) != 0),
              16'($urandom),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) < ((n % 200) < 100 ? 50 : 35)),
              1'($urandom_range(0, 3) < ((n / 100) % 4)),
              1'($urandom_range(0, 15) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
